mem_bus_responder: RTL and testbench

//  Slave end of the shared memory request bus (addr/wr/cs/rw) that the master
//  mux drives. Accepts one request at a time and runs a timed access cycle on
//  an external asynchronous 32-bit SRAM. Returns read data with a one-cycle

---
 rtl/mem_bus_responder.sv | 146 ++++++++++++++
 tb/tb_mem_bus_responder.sv | 271 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_bus_responder.sv
// Slave end of the shared memory request bus: runs one timed access cycle at a
// time on an asynchronous SRAM (setup, strobe, hold, done) and returns a ready
// pulse, plus the read data on reads.
module mem_bus_responder #(
    parameter int unsigned ADDR_W      = 22,
    parameter int unsigned DATA_W      = 32,
    parameter int unsigned WAIT_CYCLES = 2
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic [ADDR_W-1:0] i_addr,
    input  logic [DATA_W-1:0] i_wr,
    input  logic              i_cs,
    input  logic              i_rw,
    output logic [DATA_W-1:0] o_rd,
    output logic              o_ready,
    output logic              o_busy,
    output logic [ADDR_W-1:0] o_sram_addr,
    output logic [DATA_W-1:0] o_sram_dq,
    output logic              o_sram_dq_oe,
    input  logic [DATA_W-1:0] i_sram_dq,
    output logic              o_sram_ce_n,
    output logic              o_sram_oe_n,
    output logic              o_sram_we_n
);

    localparam int unsigned      CNT_W    = 4;
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(WAIT_CYCLES - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SETUP,
        S_ACCESS,
        S_HOLD,
        S_DONE
    } state_t;

    state_t            r_state;
    state_t            w_state_next;
    logic [CNT_W-1:0]  r_cnt;
    logic [CNT_W-1:0]  w_cnt_next;
    logic              r_rw;
    logic              w_accept;
    logic              w_rw_next;
    logic              w_active_next;
    logic              w_strobe_next;
    logic              w_capture;

    logic [DATA_W-1:0] r_rd;
    logic              r_ready;
    logic              r_busy;
    logic [ADDR_W-1:0] r_sram_addr;
    logic [DATA_W-1:0] r_sram_dq;
    logic              r_sram_dq_oe;
    logic              r_sram_ce_n;
    logic              r_sram_oe_n;
    logic              r_sram_we_n;

    // Next-state, strobe counter and next-cycle pin decode
    always_comb begin
        w_state_next = r_state;
        w_cnt_next   = r_cnt;
        w_accept     = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (i_cs) begin
                    w_accept     = 1'b1;
                    w_state_next = S_SETUP;
                end
            end
            S_SETUP: begin
                w_state_next = S_ACCESS;
                w_cnt_next   = CNT_LOAD;
            end
            S_ACCESS: begin
                if (r_cnt == '0) begin
                    w_state_next = S_HOLD;
                end else begin
                    w_cnt_next = r_cnt - CNT_W'(1);
                end
            end
            S_HOLD:  w_state_next = S_DONE;
            S_DONE:  w_state_next = S_IDLE;
            default: w_state_next = S_IDLE;
        endcase
        // Direction of the access that the next state belongs to
        w_rw_next     = w_accept ? i_rw : r_rw;
        w_active_next = (w_state_next == S_SETUP) || (w_state_next == S_ACCESS) ||
                        (w_state_next == S_HOLD);
        w_strobe_next = (w_state_next == S_ACCESS);
        w_capture     = (r_state == S_ACCESS) && (r_cnt == '0) && r_rw;
    end

    // State and strobe counter registers
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_next;
            r_cnt   <= w_cnt_next;
        end
    end

    // Request latch and registered SRAM/bus outputs, decoded from the next state
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_rw         <= 1'b0;
            r_rd         <= '0;
            r_ready      <= 1'b0;
            r_busy       <= 1'b0;
            r_sram_addr  <= '0;
            r_sram_dq    <= '0;
            r_sram_dq_oe <= 1'b0;
            r_sram_ce_n  <= 1'b1;
            r_sram_oe_n  <= 1'b1;
            r_sram_we_n  <= 1'b1;
        end else begin
            if (w_accept) begin
                r_rw        <= i_rw;
                r_sram_addr <= i_addr;
                r_sram_dq   <= i_wr;
            end
            if (w_capture) begin
                r_rd <= i_sram_dq;
            end
            r_ready      <= (w_state_next == S_DONE);
            r_busy       <= (w_state_next != S_IDLE);
            r_sram_ce_n  <= !w_active_next;
            r_sram_dq_oe <= w_active_next && !w_rw_next;
            r_sram_oe_n  <= !(w_strobe_next && w_rw_next);
            r_sram_we_n  <= !(w_strobe_next && !w_rw_next);
        end
    end

    assign o_rd         = r_rd;
    assign o_ready      = r_ready;
    assign o_busy       = r_busy;
    assign o_sram_addr  = r_sram_addr;
    assign o_sram_dq    = r_sram_dq;
    assign o_sram_dq_oe = r_sram_dq_oe;
    assign o_sram_ce_n  = r_sram_ce_n;
    assign o_sram_oe_n  = r_sram_oe_n;
    assign o_sram_we_n  = r_sram_we_n;

endmodule

// File: tb/tb_mem_bus_responder.sv
// Bench for mem_bus_responder: three instances (WAIT_CYCLES 2, 1, 15) on a
// behavioural SRAM, checked cycle by cycle against an access timeline model.
module tb_mem_bus_responder;

    localparam int unsigned AW = 22;
    localparam int unsigned DW = 32;
    localparam int unsigned N  = 3;

    logic          clk = 1'b0;
    logic          rst;
    logic [AW-1:0] addr      [N];
    logic [DW-1:0] wr        [N];
    logic          cs        [N];
    logic          rw        [N];
    logic [DW-1:0] rd        [N];
    logic          ready     [N];
    logic          busy      [N];
    logic [AW-1:0] sram_addr [N];
    logic [DW-1:0] sram_dq_o [N];
    logic          dq_oe     [N];
    logic [DW-1:0] sram_dq_i [N];
    logic          ce_n      [N];
    logic          oe_n      [N];
    logic          we_n      [N];

    int n_pass  = 0;
    int n_total = 0;
    int n_fail  = 0;

    logic [DW-1:0] exp_rd [N];
    logic [DW-1:0] mem [logic [AW+1:0]];
    logic [AW-1:0] pool [4];

    always #5 clk = ~clk;

    mem_bus_responder #(.ADDR_W(AW), .DATA_W(DW), .WAIT_CYCLES(2)) u_w2 (
        .i_clk(clk), .i_rst(rst), .i_addr(addr[0]), .i_wr(wr[0]), .i_cs(cs[0]), .i_rw(rw[0]),
        .o_rd(rd[0]), .o_ready(ready[0]), .o_busy(busy[0]), .o_sram_addr(sram_addr[0]),
        .o_sram_dq(sram_dq_o[0]), .o_sram_dq_oe(dq_oe[0]), .i_sram_dq(sram_dq_i[0]),
        .o_sram_ce_n(ce_n[0]), .o_sram_oe_n(oe_n[0]), .o_sram_we_n(we_n[0]));

    mem_bus_responder #(.ADDR_W(AW), .DATA_W(DW), .WAIT_CYCLES(1)) u_w1 (
        .i_clk(clk), .i_rst(rst), .i_addr(addr[1]), .i_wr(wr[1]), .i_cs(cs[1]), .i_rw(rw[1]),
        .o_rd(rd[1]), .o_ready(ready[1]), .o_busy(busy[1]), .o_sram_addr(sram_addr[1]),
        .o_sram_dq(sram_dq_o[1]), .o_sram_dq_oe(dq_oe[1]), .i_sram_dq(sram_dq_i[1]),
        .o_sram_ce_n(ce_n[1]), .o_sram_oe_n(oe_n[1]), .o_sram_we_n(we_n[1]));

    mem_bus_responder #(.ADDR_W(AW), .DATA_W(DW), .WAIT_CYCLES(15)) u_w15 (
        .i_clk(clk), .i_rst(rst), .i_addr(addr[2]), .i_wr(wr[2]), .i_cs(cs[2]), .i_rw(rw[2]),
        .o_rd(rd[2]), .o_ready(ready[2]), .o_busy(busy[2]), .o_sram_addr(sram_addr[2]),
        .o_sram_dq(sram_dq_o[2]), .o_sram_dq_oe(dq_oe[2]), .i_sram_dq(sram_dq_i[2]),
        .o_sram_ce_n(ce_n[2]), .o_sram_oe_n(oe_n[2]), .o_sram_we_n(we_n[2]));

    function automatic int wc(input int idx);
        case (idx)
            0:       return 2;
            1:       return 1;
            default: return 15;
        endcase
    endfunction

    // SRAM contents; unwritten locations return an address-derived pattern
    function automatic logic [DW-1:0] mem_rd(input int idx, input logic [AW-1:0] a);
        logic [AW+1:0] key;
        key = {2'(idx), a};
        if (mem.exists(key)) return mem[key];
        return {10'h2A5, a};
    endfunction

    // SRAM drives data only while selected with oe_n low; otherwise garbage
    always @(negedge clk) begin
        for (int i = 0; i < int'(N); i++) begin
            if (oe_n[i] === 1'b0 && ce_n[i] === 1'b0) sram_dq_i[i] = mem_rd(i, sram_addr[i]);
            else                                      sram_dq_i[i] = 32'hBADBAD00;
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        n_total++;
        assert (obs === expv) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    // Advance one clock; a selected SRAM with we_n low stores the bus data at that edge
    task automatic tick();
        for (int i = 0; i < int'(N); i++) begin
            if (ce_n[i] === 1'b0 && we_n[i] === 1'b0 && dq_oe[i] === 1'b1)
                mem[{2'(i), sram_addr[i]}] = sram_dq_o[i];
        end
        @(posedge clk);
        #1;
    endtask

    task automatic check_idle(input int idx, input string tag);
        chk($sformatf("%s_busy[%0d]", tag, idx),  64'(busy[idx]),  64'(1'b0));
        chk($sformatf("%s_ready[%0d]", tag, idx), 64'(ready[idx]), 64'(1'b0));
        chk($sformatf("%s_ce_n[%0d]", tag, idx),  64'(ce_n[idx]),  64'(1'b1));
        chk($sformatf("%s_oe_n[%0d]", tag, idx),  64'(oe_n[idx]),  64'(1'b1));
        chk($sformatf("%s_we_n[%0d]", tag, idx),  64'(we_n[idx]),  64'(1'b1));
        chk($sformatf("%s_dq_oe[%0d]", tag, idx), 64'(dq_oe[idx]), 64'(1'b0));
        chk($sformatf("%s_rd[%0d]", tag, idx),    64'(rd[idx]),    64'(exp_rd[idx]));
    endtask

    // One complete access; every cycle is compared with the expected pin timeline.
    // Cycle k counts clocks after the edge that accepted the request.
    task automatic do_access(input int idx, input bit is_read, input logic [AW-1:0] a,
                             input logic [DW-1:0] d, input bit garble, input string tag);
        int            w;
        int            oe_lo;
        int            we_lo;
        int            rdy_at;
        bit            act;
        bit            strobe;
        logic [DW-1:0] new_rd;
        w      = wc(idx);
        oe_lo  = 0;
        we_lo  = 0;
        rdy_at = -1;
        new_rd = is_read ? mem_rd(idx, a) : exp_rd[idx];
        cs[idx]   = 1'b1;
        rw[idx]   = is_read;
        addr[idx] = a;
        wr[idx]   = d;
        for (int k = 1; k <= w + 3; k++) begin
            tick();
            act    = (k <= w + 2);
            strobe = (k >= 2) && (k <= w + 1);
            chk($sformatf("%s_busy[k=%0d]", tag, k),  64'(busy[idx]),  64'(1'b1));
            chk($sformatf("%s_ready[k=%0d]", tag, k), 64'(ready[idx]), 64'(k == w + 3));
            chk($sformatf("%s_ce_n[k=%0d]", tag, k),  64'(ce_n[idx]),  64'(!act));
            chk($sformatf("%s_oe_n[k=%0d]", tag, k),  64'(oe_n[idx]),  64'(!(strobe && is_read)));
            chk($sformatf("%s_we_n[k=%0d]", tag, k),  64'(we_n[idx]),  64'(!(strobe && !is_read)));
            chk($sformatf("%s_dq_oe[k=%0d]", tag, k), 64'(dq_oe[idx]), 64'(act && !is_read));
            chk($sformatf("%s_strobe_excl[k=%0d]", tag, k), 64'(oe_n[idx] | we_n[idx]), 64'(1'b1));
            if (act)
                chk($sformatf("%s_sram_addr[k=%0d]", tag, k), 64'(sram_addr[idx]), 64'(a));
            if (act && !is_read)
                chk($sformatf("%s_sram_dq[k=%0d]", tag, k), 64'(sram_dq_o[idx]), 64'(d));
            chk($sformatf("%s_rd[k=%0d]", tag, k), 64'(rd[idx]),
                64'((k >= w + 2) ? new_rd : exp_rd[idx]));
            if (oe_n[idx] === 1'b0) oe_lo++;
            if (we_n[idx] === 1'b0) we_lo++;
            if (ready[idx] === 1'b1) rdy_at = k;
            if (garble && k < w + 3) begin
                addr[idx] = AW'($urandom);
                wr[idx]   = DW'($urandom);
                rw[idx]   = 1'($urandom);
                cs[idx]   = 1'($urandom);
            end else begin
                cs[idx] = 1'b0;
            end
        end
        exp_rd[idx] = new_rd;
        chk($sformatf("%s_oe_low_cycles", tag), 64'(oe_lo), 64'(is_read ? w : 0));
        chk($sformatf("%s_we_low_cycles", tag), 64'(we_lo), 64'(is_read ? 0 : w));
        chk($sformatf("%s_ready_cycle", tag), 64'(rdy_at), 64'(w + 3));
        tick();
        check_idle(idx, $sformatf("%s_after", tag));
    endtask

    initial begin
        int            t;
        int            pulses;
        logic [AW-1:0] ra;
        logic [DW-1:0] rdat;
        bit            rr;
        int            ri;

        rst = 1'b1;
        for (int i = 0; i < int'(N); i++) begin
            cs[i] = 1'b0; rw[i] = 1'b0; addr[i] = '0; wr[i] = '0; exp_rd[i] = '0;
        end
        pool[0] = 22'h000010; pool[1] = 22'h2ABCDE; pool[2] = 22'h3FFFFE; pool[3] = 22'h015A5A;
        tick();
        tick();

        // Reset values on every instance
        for (int i = 0; i < int'(N); i++) begin
            check_idle(i, "reset");
            chk($sformatf("reset_sram_addr[%0d]", i), 64'(sram_addr[i]), 64'(0));
            chk($sformatf("reset_sram_dq[%0d]", i),   64'(sram_dq_o[i]), 64'(0));
        end
        rst = 1'b0;
        tick();

        // Read of a preloaded location at the top of the address space
        mem[{2'd0, 22'h3FFFFF}] = 32'h12345678;
        do_access(0, 1'b1, 22'h3FFFFF, 32'h0, 1'b0, "read_top");
        chk("read_top_value", 64'(rd[0]), 64'(32'h12345678));

        // Write, then read it back through the SRAM
        do_access(0, 1'b0, 22'h15A5A, 32'hDEADBEEF, 1'b0, "write");
        chk("write_rd_unchanged", 64'(rd[0]), 64'(32'h12345678));
        do_access(0, 1'b1, 22'h15A5A, 32'h0, 1'b0, "write_readback");
        chk("write_readback_value", 64'(rd[0]), 64'(32'hDEADBEEF));

        // Reset held two cycles in the middle of a write strobe, request still asserted
        cs[0] = 1'b1; rw[0] = 1'b0; addr[0] = 22'h00777; wr[0] = 32'h0BADF00D;
        tick();
        cs[0] = 1'b0;
        tick();
        chk("rst_pre_we_n", 64'(we_n[0]), 64'(1'b0));
        cs[0] = 1'b1;
        rst   = 1'b1;
        for (int i = 0; i < int'(N); i++) exp_rd[i] = '0;
        tick();
        check_idle(0, "rst_edge1");
        tick();
        check_idle(0, "rst_edge2");
        cs[0] = 1'b0;
        rst   = 1'b0;
        for (int c = 0; c < 8; c++) begin
            tick();
            chk($sformatf("rst_after_ready[%0d]", c), 64'(ready[0]), 64'(1'b0));
            chk($sformatf("rst_after_busy[%0d]", c),  64'(busy[0]),  64'(1'b0));
        end
        check_idle(1, "rst_other");
        check_idle(2, "rst_other");

        // Request inputs churn while busy; only the latched request may reach the pins
        do_access(0, 1'b0, 22'h0ABCD, 32'hCAFEF00D, 1'b1, "busy_write");
        do_access(0, 1'b1, 22'h0ABCD, 32'h0, 1'b1, "busy_read");
        chk("busy_read_value", 64'(rd[0]), 64'(32'hCAFEF00D));

        // cs held for 12 cycles: two accesses, ready 6 cycles apart
        cs[0] = 1'b1; rw[0] = 1'b1; addr[0] = 22'h3FFFFF; wr[0] = '0;
        pulses = 0;
        for (t = 1; t <= 20; t++) begin
            tick();
            if (t == 12) cs[0] = 1'b0;
            chk($sformatf("b2b_ready[t=%0d]", t), 64'(ready[0]), 64'((t == 5) || (t == 11)));
            chk($sformatf("b2b_busy[t=%0d]", t), 64'(busy[0]),
                64'(((t >= 1) && (t <= 5)) || ((t >= 7) && (t <= 11))));
            if (ready[0] === 1'b1) begin
                pulses++;
                chk($sformatf("b2b_rd[t=%0d]", t), 64'(rd[0]), 64'(32'h12345678));
            end
        end
        chk("b2b_pulses", 64'(pulses), 64'(2));
        exp_rd[0] = 32'h12345678;

        // Shortest and longest strobe widths
        do_access(1, 1'b1, 22'h2ABCDE, 32'h0, 1'b0, "w1_read");
        do_access(2, 1'b1, 22'h1F0F0F, 32'h0, 1'b0, "w15_read");
        do_access(1, 1'b0, 22'h000010, 32'hA5A55A5A, 1'b1, "w1_write");
        do_access(1, 1'b1, 22'h000010, 32'h0, 1'b0, "w1_readback");
        chk("w1_readback_value", 64'(rd[1]), 64'(32'hA5A55A5A));

        // Randomized mix over a small address pool so reads hit earlier writes
        for (int n = 0; n < 14; n++) begin
            ri   = int'($urandom_range(0, 2));
            rr   = 1'($urandom);
            ra   = pool[$urandom_range(0, 3)];
            rdat = DW'($urandom);
            do_access(ri, rr, ra, rdat, 1'($urandom), $sformatf("rand%0d", n));
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
